// File: rtl/sfifo_uart_tx.sv
// sfifo_uart_tx: drains an 8-bit synchronous FIFO and serializes each byte as a UART frame.
// Define SFIFO_UART_TX_PARITY_EN to insert an even-parity bit between the data and stop bits.
//
// state  | meaning
// IDLE   | line high, waiting for tx_enable with a non-empty FIFO
// READ   | fifo_read_n low for exactly one cycle
// LOAD   | FIFO data captured, baud counter and bit index cleared
// START  | start bit (low)
// DATA   | data bits, LSB first
// PARITY | even parity of the captured byte (SFIFO_UART_TX_PARITY_EN only)
// STOP   | stop bit (high); frame_done in its final cycle
module sfifo_uart_tx #(
  parameter int DATA_WIDTH   = 8,
  parameter int CLKS_PER_BIT = 16,
  parameter int CNT_BITS     = 4,
  parameter int IDX_BITS     = 3
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  tx_enable,
  input  logic                  fifo_empty,
  input  logic [DATA_WIDTH-1:0] fifo_data,
  output logic                  fifo_read_n,
  output logic                  tx_serial,
  output logic                  busy,
  output logic                  frame_done
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_READ   = 3'd1,
    S_LOAD   = 3'd2,
    S_START  = 3'd3,
    S_DATA   = 3'd4,
`ifdef SFIFO_UART_TX_PARITY_EN
    S_PARITY = 3'd5,
`endif
    S_STOP   = 3'd6
  } state_t;

  localparam logic [CNT_BITS-1:0] CNT_LAST = CNT_BITS'(CLKS_PER_BIT - 1);
  localparam logic [IDX_BITS-1:0] IDX_LAST = IDX_BITS'(DATA_WIDTH - 1);

  state_t                state_q, state_d;
  logic [CNT_BITS-1:0]   cnt_q, cnt_d;
  logic [IDX_BITS-1:0]   idx_q, idx_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic                  tx_q, tx_d;
  logic                  done_q, done_d;
  logic                  bit_end;
  logic                  serial_st;
`ifdef SFIFO_UART_TX_PARITY_EN
  logic                  parity_q;
`endif

  assign bit_end = (cnt_q == CNT_LAST);

  always_comb begin
    serial_st = (state_q == S_START) || (state_q == S_DATA) || (state_q == S_STOP);
`ifdef SFIFO_UART_TX_PARITY_EN
    serial_st = serial_st || (state_q == S_PARITY);
`endif
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    if (serial_st) cnt_d = bit_end ? '0 : cnt_q + 1'b1;
    case (state_q)
      S_IDLE:  if (tx_enable && !fifo_empty) state_d = S_READ;
      S_READ:  state_d = S_LOAD;
      S_LOAD: begin
        shift_d = fifo_data;
        cnt_d   = '0;
        idx_d   = '0;
        state_d = S_START;
      end
      S_START: if (bit_end) state_d = S_DATA;
      S_DATA: begin
        if (bit_end) begin
          shift_d = shift_q >> 1;
          if (idx_q == IDX_LAST) begin
`ifdef SFIFO_UART_TX_PARITY_EN
            state_d = S_PARITY;
`else
            state_d = S_STOP;
`endif
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
`ifdef SFIFO_UART_TX_PARITY_EN
      S_PARITY: if (bit_end) state_d = S_STOP;
`endif
      S_STOP:  if (bit_end) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Line and done flops are driven from next-state values so they line up with state_q.
  always_comb begin
    tx_d = 1'b1;
    case (state_d)
      S_START:  tx_d = 1'b0;
      S_DATA:   tx_d = shift_d[0];
`ifdef SFIFO_UART_TX_PARITY_EN
      S_PARITY: tx_d = parity_q;
`endif
      default:  tx_d = 1'b1;
    endcase
    done_d = (state_d == S_STOP) && (cnt_d == CNT_LAST);
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
      done_q  <= done_d;
    end
  end

`ifdef SFIFO_UART_TX_PARITY_EN
  always_ff @(posedge clock) begin
    if (!reset_n)               parity_q <= 1'b0;
    else if (state_q == S_LOAD) parity_q <= ^fifo_data;
  end
`endif

  assign fifo_read_n = (state_q != S_READ);
  assign busy        = (state_q != S_IDLE);
  assign tx_serial   = tx_q;
  assign frame_done  = done_q;

endmodule

// File: tb/tb_sfifo_uart_tx.sv
// Directed bench for sfifo_uart_tx: behavioural FIFO feeding the DUT, frames checked against hand-computed bit patterns.
module tb_sfifo_uart_tx;
  localparam int CPB = 16;
`ifdef SFIFO_UART_TX_PARITY_EN
  localparam int NB = 11;
  localparam logic [10:0] F_A5 = 11'h54A, F_00 = 11'h400, F_FF = 11'h5FE,
                          F_3C = 11'h478, F_96 = 11'h52C, F_C3 = 11'h586;
`else
  localparam int NB = 10;
  localparam logic [10:0] F_A5 = 11'h34A, F_00 = 11'h200, F_FF = 11'h3FE,
                          F_3C = 11'h278, F_96 = 11'h32C, F_C3 = 11'h386;
`endif
  localparam int FRAME = 2 + NB * CPB;

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic       tx_enable = 1'b0;
  logic       fifo_empty = 1'b1;
  logic [7:0] fifo_data = 8'h00;
  logic       fifo_read_n, tx_serial, busy, frame_done;

  logic [7:0] fifo_q[$];
  int total = 0, bad = 0, rd_cnt = 0, dn_cnt = 0;
  int drop_at = -1, rst_at = -1;

  bit          cap_got, cap_stable;
  logic [10:0] cap_line;
  int          cap_busy, cap_dones, cap_done_pos, cap_wait;
  logic        cap_idle_tx;

  sfifo_uart_tx #(.DATA_WIDTH(8), .CLKS_PER_BIT(CPB), .CNT_BITS(4), .IDX_BITS(3)) dut (
    .clock(clock), .reset_n(reset_n), .tx_enable(tx_enable), .fifo_empty(fifo_empty),
    .fifo_data(fifo_data), .fifo_read_n(fifo_read_n), .tx_serial(tx_serial),
    .busy(busy), .frame_done(frame_done)
  );

  always #5 clock = ~clock;

  // FIFO model: pops during the strobe cycle so data is stable through LOAD.
  always @(negedge clock) begin
    if (fifo_read_n === 1'b0) begin
      rd_cnt++;
      if (fifo_q.size() > 0) fifo_data = fifo_q.pop_front();
    end
    if (frame_done === 1'b1) dn_cnt++;
    fifo_empty = (fifo_q.size() == 0);
  end

  // Waits for a read strobe, then records one frame sampled mid-bit until busy drops.
  task automatic capture_frame(input int budget);
    int c, k, o;
    logic first;
    cap_got = 0; cap_stable = 1; cap_line = '0; cap_busy = 0;
    cap_dones = 0; cap_done_pos = -1; cap_wait = 0; cap_idle_tx = 1'bx;
    first = 1'b0;
    while (cap_wait < budget) begin
      @(negedge clock);
      if (fifo_read_n === 1'b0) begin
        cap_got = 1;
        break;
      end
      cap_wait++;
    end
    if (!cap_got) return;
    c = 0;
    while (busy === 1'b1 && c < FRAME + 8) begin
      cap_busy++;
      if (frame_done === 1'b1) begin
        cap_dones++;
        cap_done_pos = c;
      end
      if (c < 2) begin
        if (tx_serial !== 1'b1) cap_stable = 0;
      end else if (c < FRAME) begin
        k = (c - 2) / CPB;
        o = (c - 2) % CPB;
        if (o == 0) first = tx_serial;
        else if (tx_serial !== first) cap_stable = 0;
        if (o == CPB / 2) cap_line[k] = tx_serial;
      end
      if (c == drop_at) tx_enable = 1'b0;
      if (c == rst_at) reset_n = 1'b0;
      c++;
      @(negedge clock);
    end
    cap_idle_tx = tx_serial;
  endtask

  task automatic test_reset();
    int n;
    fifo_q.push_back(8'h5A);
    tx_enable = 1'b1;
    reset_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      total++;
      if (tx_serial !== 1'b1) begin bad++; $display("FAIL reset_tx[%0d] got=%b exp=1", i, tx_serial); end
      total++;
      if (fifo_read_n !== 1'b1) begin bad++; $display("FAIL reset_rd[%0d] got=%b exp=1", i, fifo_read_n); end
      total++;
      if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy[%0d] got=%b exp=0", i, busy); end
    end
    reset_n = 1'b1;
    @(negedge clock);
    total++;
    if (fifo_read_n !== 1'b0) begin bad++; $display("FAIL reset_first_read got=%b exp=0", fifo_read_n); end
    n = 0;
    while (busy === 1'b1 && n < FRAME + 20) begin
      @(negedge clock);
      n++;
    end
    total++;
    if (busy !== 1'b0) begin bad++; $display("FAIL reset_drain busy got=%b exp=0", busy); end
  endtask

  task automatic test_single();
    int rd0, dn0;
    rd0 = rd_cnt; dn0 = dn_cnt;
    fifo_q.push_back(8'hA5);
    capture_frame(10);
    total++;
    if (!cap_got) begin bad++; $display("FAIL single_read got=none exp=strobe"); end
    total++;
    if (cap_line !== F_A5) begin bad++; $display("FAIL single_bits got=%h exp=%h", cap_line, F_A5); end
    total++;
    if (!cap_stable) begin bad++; $display("FAIL single_stable got=0 exp=1"); end
    total++;
    if (cap_busy !== FRAME) begin bad++; $display("FAIL single_busy_len got=%0d exp=%0d", cap_busy, FRAME); end
    total++;
    if (cap_dones !== 1) begin bad++; $display("FAIL single_done_cnt got=%0d exp=1", cap_dones); end
    total++;
    if (cap_done_pos !== FRAME - 1) begin bad++; $display("FAIL single_done_pos got=%0d exp=%0d", cap_done_pos, FRAME - 1); end
    total++;
    if (rd_cnt - rd0 !== 1) begin bad++; $display("FAIL single_read_cycles got=%0d exp=1", rd_cnt - rd0); end
    total++;
    if (dn_cnt - dn0 !== 1) begin bad++; $display("FAIL single_done_pulses got=%0d exp=1", dn_cnt - dn0); end
    total++;
    if (cap_idle_tx !== 1'b1) begin bad++; $display("FAIL single_idle_tx got=%b exp=1", cap_idle_tx); end
  endtask

  task automatic test_empty();
    int rd_lo, tx_lo, busy_hi;
    rd_lo = 0; tx_lo = 0; busy_hi = 0;
    tx_enable = 1'b1;
    for (int i = 0; i < 500; i++) begin
      @(negedge clock);
      if (fifo_read_n !== 1'b1) rd_lo++;
      if (tx_serial !== 1'b1) tx_lo++;
      if (busy !== 1'b0) busy_hi++;
    end
    total++;
    if (rd_lo !== 0) begin bad++; $display("FAIL empty_reads got=%0d exp=0", rd_lo); end
    total++;
    if (tx_lo !== 0) begin bad++; $display("FAIL empty_tx_low got=%0d exp=0", tx_lo); end
    total++;
    if (busy_hi !== 0) begin bad++; $display("FAIL empty_busy got=%0d exp=0", busy_hi); end
  endtask

  task automatic test_back_to_back();
    logic [10:0] exp_line[3];
    int rd0, dn0;
    exp_line[0] = F_00; exp_line[1] = F_FF; exp_line[2] = F_3C;
    tx_enable = 1'b0;
    fifo_q.push_back(8'h00); fifo_q.push_back(8'hFF); fifo_q.push_back(8'h3C);
    @(negedge clock); @(negedge clock);
    rd0 = rd_cnt; dn0 = dn_cnt;
    tx_enable = 1'b1;
    for (int i = 0; i < 3; i++) begin
      capture_frame(i == 0 ? 10 : 4);
      total++;
      if (cap_line !== exp_line[i]) begin bad++; $display("FAIL b2b_bits[%0d] got=%h exp=%h", i, cap_line, exp_line[i]); end
      total++;
      if (!cap_stable || cap_dones !== 1) begin
        bad++; $display("FAIL b2b_frame[%0d] got stable=%0d dones=%0d exp stable=1 dones=1", i, cap_stable, cap_dones);
      end
      if (i > 0) begin
        total++;
        if (cap_wait !== 0) begin bad++; $display("FAIL b2b_gap[%0d] got=%0d exp=3 high cycles", i, cap_wait + 3); end
      end
    end
    total++;
    if (rd_cnt - rd0 !== 3) begin bad++; $display("FAIL b2b_reads got=%0d exp=3", rd_cnt - rd0); end
    total++;
    if (dn_cnt - dn0 !== 3) begin bad++; $display("FAIL b2b_dones got=%0d exp=3", dn_cnt - dn0); end
  endtask

  task automatic test_enable_drop();
    int rd0, tx_lo, busy_hi;
    tx_enable = 1'b0;
    fifo_q.push_back(8'h96); fifo_q.push_back(8'h41);
    @(negedge clock); @(negedge clock);
    tx_enable = 1'b1;
    drop_at = 2 + 4 * CPB + 5;
    capture_frame(4);
    drop_at = -1;
    total++;
    if (cap_line !== F_96) begin bad++; $display("FAIL drop_bits got=%h exp=%h", cap_line, F_96); end
    total++;
    if (cap_dones !== 1 || cap_busy !== FRAME) begin
      bad++; $display("FAIL drop_frame got dones=%0d busy=%0d exp dones=1 busy=%0d", cap_dones, cap_busy, FRAME);
    end
    rd0 = rd_cnt; tx_lo = 0; busy_hi = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clock);
      if (tx_serial !== 1'b1) tx_lo++;
      if (busy !== 1'b0) busy_hi++;
    end
    total++;
    if (rd_cnt - rd0 !== 0) begin bad++; $display("FAIL drop_no_read got=%0d exp=0", rd_cnt - rd0); end
    total++;
    if (tx_lo !== 0 || busy_hi !== 0) begin bad++; $display("FAIL drop_idle got tx_low=%0d busy=%0d exp=0,0", tx_lo, busy_hi); end
    total++;
    if (fifo_q.size() !== 1) begin bad++; $display("FAIL drop_fifo_left got=%0d exp=1", fifo_q.size()); end
  endtask

  task automatic test_reset_mid();
    int rd0, errs;
    fifo_q.push_back(8'hC3);
    tx_enable = 1'b1;
    rst_at = 2 + 6 * CPB + 4;
    capture_frame(4);
    rst_at = -1;
    total++;
    if (cap_busy !== 2 + 6 * CPB + 5) begin bad++; $display("FAIL rstmid_busy_len got=%0d exp=%0d", cap_busy, 2 + 6 * CPB + 5); end
    total++;
    if (cap_idle_tx !== 1'b1) begin bad++; $display("FAIL rstmid_tx_after got=%b exp=1", cap_idle_tx); end
    total++;
    if (cap_dones !== 0) begin bad++; $display("FAIL rstmid_done got=%0d exp=0", cap_dones); end
    rd0 = rd_cnt; errs = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      if (tx_serial !== 1'b1 || busy !== 1'b0 || fifo_read_n !== 1'b1) errs++;
    end
    total++;
    if (errs !== 0 || rd_cnt !== rd0) begin bad++; $display("FAIL rstmid_hold got errs=%0d reads=%0d exp=0,0", errs, rd_cnt - rd0); end
    reset_n = 1'b1;
    capture_frame(4);
    total++;
    if (cap_wait !== 0) begin bad++; $display("FAIL rstmid_restart_wait got=%0d exp=0", cap_wait); end
    total++;
    if (cap_line !== F_C3) begin bad++; $display("FAIL rstmid_next_bits got=%h exp=%h", cap_line, F_C3); end
    total++;
    if (!cap_stable || cap_dones !== 1) begin
      bad++; $display("FAIL rstmid_next_frame got stable=%0d dones=%0d exp 1,1", cap_stable, cap_dones);
    end
    total++;
    if (fifo_q.size() !== 0) begin bad++; $display("FAIL rstmid_fifo_left got=%0d exp=0", fifo_q.size()); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_empty();
    test_back_to_back();
    test_enable_drop();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sfifo_uart_tx.md
Name: sfifo_uart_tx

Overview:
- Consumer end of the team's synchronous FIFO.
- Drains bytes from an 8-bit sync FIFO through its active-low read strobe and empty flag.
- Serializes each byte as an asynchronous frame: start bit, data LSB first, optional parity, stop bit.
- Sits between the FIFO output and the board-level serial pin.

Parameters:
- DATA_WIDTH, 8, FIFO word and frame data width.
- CLKS_PER_BIT, 16, clock cycles per serial bit; must be >= 2.
- CNT_BITS, 4, baud counter width; must hold CLKS_PER_BIT-1.
- IDX_BITS, 3, bit index width; must hold DATA_WIDTH-1.

Ports:
- clock  input  1  system clock, all state on posedge.
- reset_n  input  1  synchronous, active-low reset.
- tx_enable  input  1  permits starting a new frame; sampled only in IDLE.
- fifo_empty  input  1  FIFO empty flag.
- fifo_data  input  DATA_WIDTH  FIFO read data; valid the cycle after fifo_read_n is low.
- fifo_read_n  output  1  FIFO read strobe, active low, one cycle per frame.
- tx_serial  output  1  serial line, idles high.
- busy  output  1  high whenever state != IDLE.
- frame_done  output  1  one-cycle pulse in the final clock of the stop bit.

Behaviour:
- Reset: reset_n sampled low at posedge gives, after that edge:
  - state=IDLE, tx_serial=1, fifo_read_n=1, busy=0, frame_done=0.
  - Baud counter, bit index and shift register cleared.
  - Takes priority over everything; a frame in flight is abandoned and its byte is lost. The FIFO is not re-read.
- States: IDLE, READ, LOAD, START, DATA, [PARITY], STOP.
- IDLE:
  - tx_serial=1.
  - If tx_enable=1 and fifo_empty=0, go to READ; otherwise stay.
- READ (exactly 1 cycle):
  - fifo_read_n=0, decoded from state.
  - Next state LOAD.
  - fifo_read_n is never low in any other state, so no underflow read is possible.
- LOAD (1 cycle):
  - fifo_data captured into shift register.
  - Baud counter=0, bit index=0, next state START.
- START: tx_serial=0 for CLKS_PER_BIT cycles, then DATA.
- DATA:
  - tx_serial=shift[0], held CLKS_PER_BIT cycles per bit.
  - Shift right on each bit boundary.
  - After bit DATA_WIDTH-1, go to PARITY if compiled in, else STOP.
- STOP:
  - tx_serial=1 for CLKS_PER_BIT cycles.
  - frame_done=1 in the last of those cycles; next state IDLE.
- Baud counter:
  - Counts 0..CLKS_PER_BIT-1 and wraps to 0 on each bit boundary.
  - Width CNT_BITS; compare is exact, no overflow.
- Outputs:
  - tx_serial and frame_done are registered.
  - fifo_read_n and busy are decoded from the state register (glitch-free, one flop source).
- Frame timing, READ entry to STOP exit:
  - 2 + (DATA_WIDTH+2)*CLKS_PER_BIT cycles; 162 at defaults, no parity.
- Back-to-back frames: minimum inter-frame gap of 3 line-high cycles (IDLE, READ, LOAD) after the stop bit.
- Signals ignored outside IDLE:
  - tx_enable deasserted mid-frame: current frame completes, no further reads.
  - fifo_empty changes mid-frame: no effect.

Optional Feature:
- Macro: SFIFO_UART_TX_PARITY_EN.
- Defined:
  - PARITY state inserted after DATA.
  - Drives even parity (XOR of the data bits, captured at LOAD) for CLKS_PER_BIT cycles.
  - Frame becomes 2 + (DATA_WIDTH+3)*CLKS_PER_BIT cycles.
- Undefined: no PARITY state or parity logic; DATA goes directly to STOP.

Test Plan:
- Reset hold: reset_n=0 for 3 cycles, fifo_empty=0, tx_enable=1 -> tx_serial=1, fifo_read_n=1, busy=0 throughout; first read occurs 1 cycle after reset_n rises.
- Single byte 0xA5, default params, no parity:
  - fifo_read_n low exactly 1 cycle.
  - tx_serial = 0,1,0,1,0,0,1,0,1,1, each bit 16 cycles.
  - One frame_done pulse; busy high for 162 cycles.
  - With PARITY_EN: parity bit 0 inserted before stop; busy high for 178 cycles.
- Empty FIFO: fifo_empty=1, tx_enable=1 for 500 cycles -> no read strobe, tx_serial=1, busy=0.
- Back-to-back 0x00, 0xFF, 0x3C:
  - Three frames in order with exactly 3 high cycles between each stop bit and the next start bit.
  - Three read strobes, three frame_done pulses.
- tx_enable dropped during bit 3 of the first of two queued bytes -> first frame completes intact; no second read; line stays high.
- reset_n low during DATA bit 5 -> tx_serial=1 the cycle after, busy=0, no read strobe while reset is held; after release, the next queued byte is sent from its start bit.
